// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: sequences one dot product per job onto a DSP MAC slice.
// Fetches N operand pairs, drives CLR / N x MAC / optional ACC, then hands off
// the 48-bit result on a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, len            job request and MAC count (N)
//   act_base, wgt_base    operand start addresses, latched with start
//   bias                  ACC operand, latched with start
//   busy                  high from the cycle after acceptance to handshake
//   rd_en, act_addr,      shared read strobe and addresses for the two
//   wgt_addr              synchronous-read operand memories
//   act_rdata, wgt_rdata  operand data, one cycle after rd_en
//   dsp_op                00=CLR 01=MAC 10=ACC 11=NOP
//   dsp_a, dsp_b, dsp_c   DSP operand pins
//   dsp_p                 DSP accumulator output
//   res_valid, res_ready, result handshake and captured result
//   res_data
//
// Build option: define DSP_SEQ_BIAS_EN to add the BIAS state (one ACC of the
// latched bias after the last MAC). Without it dsp_c is tied to 0.

module dsp_mac_sequencer #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] act_base,
   input  logic [ADDR_W-1:0] wgt_base,
   input  logic [47:0]       bias,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] act_addr,
   output logic [ADDR_W-1:0] wgt_addr,
   input  logic [17:0]       act_rdata,
   input  logic [17:0]       wgt_rdata,
   output logic [1:0]        dsp_op,
   output logic [17:0]       dsp_a,
   output logic [17:0]       dsp_b,
   output logic [47:0]       dsp_c,
   input  logic [47:0]       dsp_p,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [47:0]       res_data
);

   localparam logic [1:0] OP_CLR = 2'b00;
   localparam logic [1:0] OP_MAC = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
`ifdef DSP_SEQ_BIAS_EN
      S_BIAS,
`endif
      S_WAIT,
      S_DONE
   } state_t;

   // State entered once the MAC stream (possibly empty) is finished.
`ifdef DSP_SEQ_BIAS_EN
   localparam state_t S_POST = S_BIAS;
`else
   localparam state_t S_POST = S_WAIT;
`endif

   state_t state_q;
   state_t state_d;

   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_m1;
   logic [LEN_W-1:0]  j_q;
   logic [ADDR_W-1:0] act_base_q;
   logic [ADDR_W-1:0] wgt_base_q;
   logic [ADDR_W-1:0] off_q;
   logic [47:0]       res_q;
   logic              load;
   logic              cap;
   logic              last;

   assign len_m1 = len_q - 1'b1;
   assign last   = (j_q == len_m1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      dsp_op  = OP_NOP;
      load    = 1'b0;
      cap     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            dsp_op = OP_CLR;
            if (len_q != '0) begin
               rd_en   = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_POST;
            end
         end
         S_RUN: begin
            dsp_op = OP_MAC;
            // The pair for the final MAC was already fetched last cycle.
            if (last) begin
               state_d = S_POST;
            end else begin
               rd_en = 1'b1;
            end
         end
`ifdef DSP_SEQ_BIAS_EN
         S_BIAS: begin
            dsp_op  = OP_ACC;
            state_d = S_WAIT;
         end
`endif
         S_WAIT: begin
            // The DSP registered the last MAC/ACC at the previous edge.
            cap     = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_q      <= '0;
         j_q        <= '0;
         act_base_q <= '0;
         wgt_base_q <= '0;
         off_q      <= '0;
         res_q      <= '0;
      end else begin
         if (load) begin
            len_q      <= len;
            act_base_q <= act_base;
            wgt_base_q <= wgt_base;
            j_q        <= '0;
            off_q      <= '0;
         end else begin
            if (rd_en) begin
               off_q <= off_q + 1'b1;
            end
            if (state_q == S_RUN) begin
               j_q <= j_q + 1'b1;
            end
         end
         if (cap) begin
            res_q <= dsp_p;
         end
      end
   end

`ifdef DSP_SEQ_BIAS_EN
   logic [47:0] bias_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bias_q <= '0;
      end else if (load) begin
         bias_q <= bias;
      end
   end

   assign dsp_c = bias_q;
`else
   logic unused_bias;

   assign unused_bias = ^bias;
   assign dsp_c       = '0;
`endif

   // Addresses wrap modulo 2^ADDR_W by construction.
   assign act_addr  = act_base_q + off_q;
   assign wgt_addr  = wgt_base_q + off_q;
   assign dsp_a     = act_rdata;
   assign dsp_b     = wgt_rdata;
   assign busy      = (state_q != S_IDLE);
   assign res_valid = (state_q == S_DONE);
   assign res_data  = res_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed, table-driven bench for dsp_mac_sequencer.
// Models two synchronous-read memories and a registered DSP accumulator.

module tb_dsp_mac_sequencer;

`ifdef DSP_SEQ_BIAS_EN
   localparam bit BIAS_ON = 1'b1;
`else
   localparam bit BIAS_ON = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  len;
   logic [9:0]  act_base;
   logic [9:0]  wgt_base;
   logic [47:0] bias;
   logic        busy;
   logic        rd_en;
   logic [9:0]  act_addr;
   logic [9:0]  wgt_addr;
   logic [17:0] act_rdata;
   logic [17:0] wgt_rdata;
   logic [1:0]  dsp_op;
   logic [17:0] dsp_a;
   logic [17:0] dsp_b;
   logic [47:0] dsp_c;
   logic [47:0] dsp_p;
   logic        res_valid;
   logic        res_ready;
   logic [47:0] res_data;

   dsp_mac_sequencer #(.ADDR_W(10), .LEN_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .act_base(act_base), .wgt_base(wgt_base), .bias(bias),
      .busy(busy), .rd_en(rd_en), .act_addr(act_addr),
      .wgt_addr(wgt_addr), .act_rdata(act_rdata),
      .wgt_rdata(wgt_rdata), .dsp_op(dsp_op), .dsp_a(dsp_a),
      .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_p(dsp_p),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [17:0] act_mem [1024];
   logic [17:0] wgt_mem [1024];

   always @(posedge clk) begin
      if (rd_en) begin
         act_rdata <= act_mem[act_addr];
         wgt_rdata <= wgt_mem[wgt_addr];
      end
   end

   logic signed [35:0] prod;
   assign prod = $signed(dsp_a) * $signed(dsp_b);

   always @(posedge clk) begin
      case (dsp_op)
         2'b00:   dsp_p <= '0;
         2'b01:   dsp_p <= dsp_p + {{12{prod[35]}}, prod};
         2'b10:   dsp_p <= dsp_p + dsp_c;
         default: dsp_p <= dsp_p;
      endcase
   end

   int n_chk;
   int n_pass;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] req);
      n_chk++;
      if (got === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h required %0h", nm, got, req);
      end
   endtask

   typedef struct {
      int                 n;
      logic [9:0]         ab;
      logic [9:0]         wb;
      logic [47:0]        bi;
      logic signed [47:0] dot;
      string              nm;
   } vec_t;

   vec_t tbl [5];

   task automatic run_job(input vec_t v);
      int          cyc;
      int          nclr;
      int          nmac;
      int          nacc;
      int          nrd;
      int          nbad;
      bit          accd;
      bit          ordbad;
      logic [47:0] exp_res;
      cyc     = 0;
      nclr    = 0;
      nmac    = 0;
      nacc    = 0;
      nrd     = 0;
      nbad    = 0;
      accd    = 1'b0;
      ordbad  = 1'b0;
      exp_res = v.dot + (BIAS_ON ? v.bi : 48'd0);
      @(negedge clk);
      start    = 1'b1;
      len      = 10'(v.n);
      act_base = v.ab;
      wgt_base = v.wb;
      bias     = v.bi;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (!res_valid && cyc < 64) begin
         case (dsp_op)
            2'b00: nclr++;
            2'b01: begin
               nmac++;
               if (accd) ordbad = 1'b1;
            end
            2'b10: begin
               nacc++;
               accd = 1'b1;
            end
            default: ;
         endcase
         if (rd_en) begin
            if (act_addr != 10'(v.ab + 10'(nrd)) ||
                wgt_addr != 10'(v.wb + 10'(nrd)))
               nbad++;
            nrd++;
         end
         @(negedge clk);
         cyc++;
      end
      chk({v.nm, "_latency"}, 64'(cyc), 64'(v.n + 3 + int'(BIAS_ON)));
      chk({v.nm, "_res"}, 64'(res_data), 64'(exp_res));
      chk({v.nm, "_clr"}, 64'(nclr), 64'd1);
      chk({v.nm, "_mac"}, 64'(nmac), 64'(v.n));
      chk({v.nm, "_acc"}, 64'(nacc), 64'(BIAS_ON));
      chk({v.nm, "_rd"}, 64'(nrd), 64'(v.n));
      chk({v.nm, "_addr"}, 64'(nbad), 64'd0);
      chk({v.nm, "_order"}, 64'(ordbad), 64'd0);
      chk({v.nm, "_dsp_c"}, 64'(dsp_c), 64'(BIAS_ON ? v.bi : 48'd0));
      @(negedge clk);
      chk({v.nm, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int          cnt;
      logic [47:0] exp_s;
      n_chk  = 0;
      n_pass = 0;
      for (int i = 0; i < 1024; i++) begin
         act_mem[i] = '0;
         wgt_mem[i] = '0;
      end
      act_mem[0]    = 18'd1;
      act_mem[1]    = 18'd2;
      act_mem[2]    = 18'd3;
      wgt_mem[100]  = 18'd4;
      wgt_mem[101]  = 18'd5;
      wgt_mem[102]  = 18'd6;
      act_mem[10]   = 18'd7;
      act_mem[11]   = 18'd8;
      wgt_mem[110]  = 18'd2;
      wgt_mem[111]  = 18'd3;
      act_mem[1022] = 18'd1;
      act_mem[1023] = 18'd2;
      for (int i = 200; i < 204; i++) wgt_mem[i] = 18'd1;
      act_mem[20]   = 18'h3FFFD;
      act_mem[21]   = 18'd5;
      wgt_mem[120]  = 18'd4;
      wgt_mem[121]  = 18'h3FFFE;
      dsp_p     = 48'h123456;
      act_rdata = '0;
      wgt_rdata = '0;

      tbl[0] = '{3, 10'd0, 10'd100, 48'd100, 48'sd32, "dot3"};
      tbl[1] = '{0, 10'd5, 10'd5, 48'd77, 48'sd0, "zero"};
      tbl[2] = '{2, 10'd10, 10'd110, 48'd100, 48'sd38, "bias2"};
      tbl[3] = '{4, 10'd1022, 10'd200, 48'd0, 48'sd6, "wrap"};
      tbl[4] = '{2, 10'd20, 10'd120, 48'hFFFF_FFFF_FFF6, -48'sd22, "neg"};

      rst_n     = 1'b0;
      start     = 1'b0;
      len       = '0;
      act_base  = '0;
      wgt_base  = '0;
      bias      = '0;
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_data", 64'(res_data), 64'd0);
      chk("rst_op", 64'(dsp_op), 64'd3);
      chk("rst_dsp_c", 64'(dsp_c), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_job(tbl[i]);

      // Stalled handshake with a start pulse that must be ignored.
      exp_s = 48'd1 + (BIAS_ON ? 48'd5 : 48'd0);
      @(negedge clk);
      res_ready = 1'b0;
      start     = 1'b1;
      len       = 10'd1;
      act_base  = 10'd0;
      wgt_base  = 10'd200;
      bias      = 48'd5;
      @(negedge clk);
      start = 1'b0;
      cnt   = 0;
      while (!res_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("stall_valid", 64'(res_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_data", 64'(res_data), 64'(exp_s));
         chk("stall_busy", 64'(busy), 64'd1);
         start = (i == 2);
         len   = 10'd3;
         @(negedge clk);
      end
      start = 1'b0;
      chk("stall_hold", 64'(res_valid), 64'd1);
      res_ready = 1'b1;
      start     = 1'b1;
      len       = 10'd0;
      @(negedge clk);
      chk("hs_idle_busy", 64'(busy), 64'd0);
      chk("hs_idle_valid", 64'(res_valid), 64'd0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_op", 64'(dsp_op), 64'd0);
      cnt = 0;
      while (!res_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("b2b_res", 64'(res_data), 64'(BIAS_ON ? 48'd5 : 48'd0));
      @(negedge clk);

      // Abort in the middle of a long job.
      start    = 1'b1;
      len      = 10'd8;
      act_base = 10'd0;
      wgt_base = 10'd200;
      bias     = 48'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_run_op", 64'(dsp_op), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_op", 64'(dsp_op), 64'd3);
      chk("abort_valid", 64'(res_valid), 64'd0);
      chk("abort_rd_en", 64'(rd_en), 64'd0);
      rst_n = 1'b1;
      run_job(tbl[2]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
